pwm_multichannel: RTL

Parametrised successor to the two-byte PWM peripheral: a multi-channel PWM generator with configurable channel count, counter width, period and prescaler, edge- or center-aligned counting, per-channel output polarity, and double-buffered duty registers. It sits between the register file (SPI peripheral or successor) and the pad outputs (`uo_out`/`uio_out`). Duty updates are glitch-free: they take effect only at a period boundary.

---
 rtl/pwm_multichannel.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with a shared prescaled counter, edge- or
// center-aligned counting, per-channel polarity/enables and double-buffered
// duty registers. Shadow duties are copied to the active set only on a period
// boundary (wrap), so a duty change never produces a runt pulse.
// Outputs are registered: out in cycle t+1 reflects cnt/active/enables of
// cycle t, and period_tick is high in the cycle after the wrap cycle.
module pwm_multichannel #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PRE_W  = 12,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  input  logic [NUM_CH-1:0] polarity,
  input  logic              mode,
  input  logic [CNT_W-1:0]  period,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              duty_wr_en,
  input  logic [CH_W-1:0]   duty_wr_ch,
  input  logic [CNT_W-1:0]  duty_wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_tick
);

  // One extra bit so channel indices >= NUM_CH are detectable.
  localparam logic [CH_W:0] ch_limit = NUM_CH[CH_W:0];

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_down_q, dir_down_d;
  logic              mode_q;
  logic              tick;
  logic              wrap;
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [NUM_CH-1:0] out_d;
  logic              wr_valid;

  assign wr_valid = duty_wr_en && ({1'b0, duty_wr_ch} < ch_limit);

  // Prescaler and counter next state; a mode change restarts everything.
  always_comb begin
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    wrap       = 1'b0;
    tick       = (pre_q >= prescale);
    if (mode != mode_q) begin
      pre_d      = '0;
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (period == '0) begin
          cnt_d      = '0;
          dir_down_d = 1'b0;
          wrap       = 1'b1;
        end else if (!mode_q) begin
          // >= so a lowered period wraps at once instead of running past TOP.
          if (cnt_q >= period) begin
            cnt_d = '0;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!dir_down_q) begin
          if (cnt_q < period) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            dir_down_d = 1'b1;
            cnt_d      = cnt_q - 1'b1;
          end
        end else if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d      = '0;
          dir_down_d = 1'b0;
          wrap       = 1'b1;
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      mode_q     <= mode;
    end
  end

  // Shadow writes and commit; commit reads the pre-write shadow value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wrap) begin
        for (int i = 0; i < NUM_CH; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (wr_valid) begin
        shadow_q[duty_wr_ch] <= duty_wr_data;
      end
    end
  end

  // Per-channel compare, enables and polarity.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_d[i] = en_out[i] & ((en_pwm[i] ? (cnt_q < active_q[i]) : 1'b1) ^ polarity[i]);
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out         <= '0;
      period_tick <= 1'b0;
    end else begin
      out         <= out_d;
      period_tick <= wrap;
    end
  end

endmodule
